// File: rtl/mux_scan_serializer_pkg.sv
// Shared constants and state encoding for the mux scan serializer.
// MUX_SCAN_PARITY_EN (see top) adds the PAR state to the sequence.
package mux_scan_serializer_pkg;

  localparam int WORD_W      = 4;
  localparam int SEL_W       = 2;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  // Prescaler width: a one-bit counter is still needed when DIV is 1.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_serializer_tick.sv
// Bit-period prescaler for the mux scan serializer: counts 0..DIV-1 and
// flags the last cycle of each period.
module mux_scan_tick
  import mux_scan_serializer_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick = i_enable && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Drives a 4:1 mux with a latched word, walks its select 0..3 and serialises
// the mux output LSB first. Define MUX_SCAN_PARITY_EN to append an even-parity bit.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] mux_d,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_y,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORD_W - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WORD_W-1:0] r_mux_d;
  logic [SEL_W-1:0]  r_sel;
  logic              r_serial_out;
  logic              r_serial_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_start;
  logic              w_enable;
  logic              w_tick;
  logic              w_bit_tick;
  logic              w_last_bit;

  assign w_start    = (r_state == ST_IDLE) && start;
  assign w_enable   = (r_state != ST_IDLE);
  assign w_bit_tick = (r_state == ST_SEND) && w_tick;
  assign w_last_bit = w_bit_tick && (r_sel == LAST_SEL);

  mux_scan_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_start),
    .i_enable (w_enable),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_SEND;
`ifdef MUX_SCAN_PARITY_EN
      ST_SEND: if (w_last_bit) w_next_state = ST_PAR;
      ST_PAR:  if (w_tick) w_next_state = ST_IDLE;
`else
      ST_SEND: if (w_last_bit) w_next_state = ST_IDLE;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_start) begin
      r_parity <= 1'b0;
    end else if (w_bit_tick) begin
      r_parity <= r_parity ^ mux_y;
    end
  end
`endif

  // Only the final prescaler cycle samples mux_y; strobes last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_d        <= '0;
      r_sel          <= '0;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_serial_valid <= 1'b0;
      r_done         <= 1'b0;
      if (w_start) begin
        r_mux_d <= data_in;
        r_sel   <= '0;
        r_busy  <= 1'b1;
      end else if (w_bit_tick) begin
        r_serial_out   <= mux_y;
        r_serial_valid <= 1'b1;
        if (r_sel != LAST_SEL) begin
          r_sel <= r_sel + 1'b1;
        end
`ifndef MUX_SCAN_PARITY_EN
        else begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
`endif
      end
`ifdef MUX_SCAN_PARITY_EN
      else if ((r_state == ST_PAR) && w_tick) begin
        r_serial_out   <= r_parity;
        r_serial_valid <= 1'b1;
        r_busy         <= 1'b0;
        r_done         <= 1'b1;
      end
`endif
    end
  end

  assign mux_d        = r_mux_d;
  assign sel          = r_sel;
  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench for mux_scan_serializer: one DIV=4 and one DIV=1 instance,
// each closing the loop through a 4:1 mux; honours MUX_SCAN_PARITY_EN.
module tb_mux_scan_serializer;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
`ifdef MUX_SCAN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic       b;
    logic       d;
    logic [1:0] s;
    int         c;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       startA, startB;
  logic [3:0] dataA, dataB;
  logic [3:0] muxDA, muxDB;
  logic [1:0] selA, selB;
  logic       muxYA, muxYB;
  logic       serA, serB, valA, valB, busyA, busyB, doneA, doneB;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   base;
  exp_t qA[$];
  exp_t qB[$];

  mux_scan_serializer #(.DIV(DIV_A)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .data_in(dataA),
    .mux_d(muxDA), .sel(selA), .mux_y(muxYA), .serial_out(serA),
    .serial_valid(valA), .busy(busyA), .done(doneA)
  );

  mux_scan_serializer #(.DIV(DIV_B)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .data_in(dataB),
    .mux_d(muxDB), .sel(selB), .mux_y(muxYB), .serial_out(serB),
    .serial_valid(valB), .busy(busyB), .done(doneB)
  );

  // Two-level 4:1 mux tree standing in for the structural mux.
  assign muxYA = selA[1] ? (selA[0] ? muxDA[3] : muxDA[2]) : (selA[0] ? muxDA[1] : muxDA[0]);
  assign muxYB = selB[1] ? (selB[0] ? muxDB[3] : muxDB[2]) : (selB[0] ? muxDB[1] : muxDB[0]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wordLen(input int div);
    return 4 * div + 1 + (PAR ? div : 0);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExpected(input bit which, input int b0, input logic [3:0] bits,
                              input logic parBit, input int nBits);
    exp_t e;
    int   div;
    div = which ? DIV_B : DIV_A;
    for (int k = 0; k < nBits; k++) begin
      e.b = bits[k];
      e.d = (k == 3) && !PAR;
      e.s = (k < 3) ? 2'(k + 1) : 2'd3;
      e.c = b0 + (k + 1) * div + 1;
      if (which) qB.push_back(e); else qA.push_back(e);
    end
    if (PAR && nBits == 4) begin
      e.b = parBit;
      e.d = 1'b1;
      e.s = 2'd3;
      e.c = b0 + 5 * div + 1;
      if (which) qB.push_back(e); else qA.push_back(e);
    end
  endtask

  // Called at a falling edge; the start is sampled by the next rising edge.
  task automatic applyStimulus(input bit which, input logic [3:0] word, input logic [3:0] bits,
                               input logic parBit, input int nBits, input bit hold,
                               output int b0);
    b0 = cyc;
    if (which) begin startB = 1'b1; dataB = word; end
    else begin startA = 1'b1; dataA = word; end
    pushExpected(which, b0, bits, parBit, nBits);
    @(negedge clk);
    if (!hold) begin
      if (which) startB = 1'b0; else startA = 1'b0;
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((qA.size() > 0 || qB.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard drained", qA.size() + qB.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, " mux_d"}, muxDA, 0);
    checkOutput({tag, " sel"}, selA, 0);
    checkOutput({tag, " serial_out"}, serA, 0);
    checkOutput({tag, " serial_valid"}, valA, 0);
    checkOutput({tag, " busy"}, busyA, 0);
    checkOutput({tag, " done"}, doneA, 0);
  endtask

  // Monitor for the DIV=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valA && qA.size() > 0) begin
        e = qA.pop_front();
        checkOutput("A bit", serA, e.b);
        checkOutput("A done", doneA, e.d);
        checkOutput("A busy", busyA, e.d ? 0 : 1);
        checkOutput("A strobe cycle", cyc, e.c);
        checkOutput("A sel", selA, e.s);
      end else if (qA.size() == 0) begin
        checkOutput("A idle strobe", valA, 0);
      end
      checkOutput("A done without strobe", doneA & ~valA, 0);
    end
  end

  // Monitor for the DIV=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valB && qB.size() > 0) begin
        e = qB.pop_front();
        checkOutput("B bit", serB, e.b);
        checkOutput("B done", doneB, e.d);
        checkOutput("B busy", busyB, e.d ? 0 : 1);
        checkOutput("B strobe cycle", cyc, e.c);
        checkOutput("B sel", selB, e.s);
      end else if (qB.size() == 0) begin
        checkOutput("B idle strobe", valB, 0);
      end
      checkOutput("B done without strobe", doneB & ~valB, 0);
    end
  end

  initial begin
    rst_n  = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    dataA  = 4'b0000;
    dataB  = 4'b0000;
    repeat (3) @(negedge clk);
    checkResetA("reset");
    checkOutput("reset B busy", busyB, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic words: 1010 at DIV=4, 0110 at DIV=1");
    applyStimulus(1'b0, 4'b1010, 4'b1010, 1'b0, 4, 1'b0, base);
    applyStimulus(1'b1, 4'b0110, 4'b0110, 1'b0, 4, 1'b0, base);
    waitDrain();
    checkOutput("A sel parks at 3", selA, 3);
    checkOutput("A mux_d keeps word", muxDA, 4'b1010);

    $display("[TB] back-to-back words with start held high");
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, 4, 1'b1, base);
    pushExpected(1'b0, base + wordLen(DIV_A), 4'b0000, 1'b0, 4);
    waitUntil(base + 3);
    dataA = 4'b0000;
    waitUntil(base + wordLen(DIV_A) + 1);
    startA = 1'b0;
    waitDrain();

    $display("[TB] start while busy is ignored");
    applyStimulus(1'b0, 4'b0011, 4'b0011, 1'b0, 4, 1'b0, base);
    waitUntil(base + 6);
    startA = 1'b1;
    dataA  = 4'b1100;
    @(negedge clk);
    startA = 1'b0;
    waitDrain();

    $display("[TB] reset mid-word after bit 1");
    applyStimulus(1'b0, 4'b1010, 4'b1010, 1'b0, 2, 1'b0, base);
    waitUntil(base + 2 * DIV_A + 2);
    checkOutput("A busy before reset", busyA, 1);
    rst_n = 1'b0;
    #1;
    checkResetA("mid-word reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4, 1'b0, base);
    waitDrain();

`ifdef MUX_SCAN_PARITY_EN
    $display("[TB] parity words");
    applyStimulus(1'b0, 4'b1011, 4'b1011, 1'b1, 4, 1'b0, base);
    waitDrain();
    applyStimulus(1'b0, 4'b1010, 4'b1010, 1'b0, 4, 1'b0, base);
    waitDrain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
